// File: rtl/mips_pkg.sv
// mips_pkg
// Shared constants for the multi-cycle MIPS main controller:
//   - instruction opcode and R-type funct codes
//   - ALU select codes driven to the ALU
//   - aluop codes passed to the ALU decoder
//   - alu_src_b and pc_src mux encodings
//   - controller state encoding (exported on the debug state port)
package mips_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU select codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // aluop: what the ALU decoder should produce
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // alu_src_b mux
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  // pc_src mux
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Controller states; codes 12-15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder
// Combinational map from (aluop, funct) to the 3-bit ALU select code.
// Ports:
//   aluop_i       in  2  ADD / SUB / decode-from-funct
//   funct_i       in  6  IR[5:0]
//   alu_select_o  out 3  ALU operation code
//   funct_legal_o out 1  funct is one of add/sub/and/or/slt (independent of aluop)
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_select_o,
  output logic       funct_legal_o
);

  logic [2:0] funct_sel;

  always_comb begin
    funct_sel     = ALU_ADD;
    funct_legal_o = 1'b1;
    case (funct_i)
      FN_ADD:  funct_sel = ALU_ADD;
      FN_SUB:  funct_sel = ALU_SUB;
      FN_AND:  funct_sel = ALU_AND;
      FN_OR:   funct_sel = ALU_OR;
      FN_SLT:  funct_sel = ALU_SLT;
      default: funct_legal_o = 1'b0;
    endcase
  end

  always_comb begin
    alu_select_o = ALU_ADD;
    case (aluop_i)
      ALUOP_SUB:   alu_select_o = ALU_SUB;
      ALUOP_FUNCT: alu_select_o = funct_sel;
      default:     alu_select_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Moore main controller for the multi-cycle MIPS datapath. Sequences
// fetch / decode / execute / memory / writeback over 3-5 cycles.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   opcode, funct      IR fields, stable from DECODE until the next FETCH
//   zero               ALU ZERO flag (used only in BRANCH)
//   alu_select         ALU operation code
//   alu_src_a/b        ALU operand muxes
//   iord               memory address select
//   ir_write, mem_write, reg_write  write enables (at most one high)
//   reg_dst, mem_to_reg register-file destination / data muxes
//   pc_src, pc_en      PC next-value mux and load enable
//   illegal_op         high in DECODE for an unsupported instruction
//   state              current state for debug
// Outputs are decoded from the state register only (plus IR fields that
// the IR holds stable), so they behave as Moore outputs. Enables are gated
// by rst_n so nothing fires while reset is held, even though state is FETCH.
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_select,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [1:0] aluop;
  logic       funct_legal;
  logic       pc_write, branch;
  logic       ir_write_raw, mem_write_raw, reg_write_raw;
  logic       decode_illegal;

  alu_decoder u_alu_decoder (
    .aluop_i       (aluop),
    .funct_i       (funct),
    .alu_select_o  (alu_select),
    .funct_legal_o (funct_legal)
  );

  // Instruction legality as seen in DECODE.
  always_comb begin
    decode_illegal = 1'b1;
    case (opcode)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: decode_illegal = 1'b0;
      OP_RTYPE:                            decode_illegal = !funct_legal;
      default:                             decode_illegal = 1'b1;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_legal ? S_EXECUTE : S_FETCH;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Per-state output decode. Unused codes fall to the all-zero default.
  always_comb begin
    aluop         = ALUOP_ADD;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    iord          = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    pc_src        = PCSRC_ALU;
    pc_write      = 1'b0;
    branch        = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b    = SRCB_FOUR;
        ir_write_raw = 1'b1;
        pc_write     = 1'b1;
      end
      // Branch target precomputed into ALUOut while decoding.
      S_DECODE: alu_src_b = SRCB_IMMSH2;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
      end
      S_MEMWR: begin
        iord          = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: reg_write_raw = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign ir_write   = rst_n & ir_write_raw;
  assign mem_write  = rst_n & mem_write_raw;
  assign reg_write  = rst_n & reg_write_raw;
  // zero only matters when branch is set, i.e. in BRANCH.
  assign pc_en      = rst_n & (pc_write | (branch & zero));
  assign illegal_op = rst_n & (state_q == S_DECODE) & decode_illegal;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;

  logic [2:0] alu_select;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg;
  logic [1:0] pc_src;
  logic       pc_en, illegal_op;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .alu_select (alu_select),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .iord       (iord),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .pc_src     (pc_src),
    .pc_en      (pc_en),
    .illegal_op (illegal_op),
    .state      (state)
  );

  // ---------------- vector table ----------------
  // Expected outputs packed as
  // {state4, sel3, a1, b2, iord1, ir1, mw1, rw1, rd1, m2r1, pcsrc2, pcen1, ill1}
  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [19:0] pack_exp(
    input logic [3:0] st, input logic [2:0] sel, input logic a,
    input logic [1:0] b, input logic io, input logic ir, input logic mw,
    input logic rw, input logic rd, input logic m2r, input logic [1:0] pcs,
    input logic pce, input logic ill);
    return {st, sel, a, b, io, ir, mw, rw, rd, m2r, pcs, pce, ill};
  endfunction

  function automatic logic [19:0] dut_pack();
    return {state, alu_select, alu_src_a, alu_src_b, iord, ir_write, mem_write,
            reg_write, reg_dst, mem_to_reg, pc_src, pc_en, illegal_op};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic [19:0] e);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.exp = e;
    vecs.push_back(v);
  endtask

  // Common FETCH and DECODE rows.
  task automatic add_fetch(input logic [5:0] op, input logic [5:0] fn, input logic z);
    add(op, fn, z, pack_exp(4'd0, 3'b010, 0, 2'b01, 0, 1, 0, 0, 0, 0, 2'b00, 1, 0));
  endtask

  task automatic add_decode(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input logic ill);
    add(op, fn, z, pack_exp(4'd1, 3'b010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 0, ill));
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, want);
    end
  endtask

  task automatic add_rtype(input logic [5:0] fn, input logic [2:0] sel);
    add_fetch(OP_RTYPE, fn, 0);
    add_decode(OP_RTYPE, fn, 0, 0);
    add(OP_RTYPE, fn, 1, pack_exp(4'd6, sel, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    add(OP_RTYPE, fn, 0, pack_exp(4'd7, 3'b010, 0, 2'b00, 0, 0, 0, 1, 1, 0, 2'b00, 0, 0));
  endtask

  task automatic build_table();
    // lw: 0,1,2,3,4
    add_fetch(OP_LW, 6'd0, 0);
    add_decode(OP_LW, 6'd0, 0, 0);
    add(OP_LW, 6'd0, 0, pack_exp(4'd2, 3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    add(OP_LW, 6'd0, 0, pack_exp(4'd3, 3'b010, 0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    add(OP_LW, 6'd0, 0, pack_exp(4'd4, 3'b010, 0, 2'b00, 0, 0, 0, 1, 0, 1, 2'b00, 0, 0));
    // R-type sweep
    add_rtype(FN_ADD, 3'b010);
    add_rtype(FN_SUB, 3'b110);
    add_rtype(FN_AND, 3'b000);
    add_rtype(FN_OR,  3'b001);
    add_rtype(FN_SLT, 3'b111);
    // beq taken, zero also high in FETCH/DECODE (no extra effect)
    add_fetch(OP_BEQ, 6'd0, 1);
    add_decode(OP_BEQ, 6'd0, 1, 0);
    add(OP_BEQ, 6'd0, 1, pack_exp(4'd8, 3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 1, 0));
    // beq not taken
    add_fetch(OP_BEQ, 6'd0, 0);
    add_decode(OP_BEQ, 6'd0, 0, 0);
    add(OP_BEQ, 6'd0, 0, pack_exp(4'd8, 3'b110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0));
    // illegal opcode, then R-type with illegal funct
    add_fetch(6'b111111, 6'd0, 0);
    add_decode(6'b111111, 6'd0, 0, 1);
    add_fetch(OP_RTYPE, 6'b000001, 0);
    add_decode(OP_RTYPE, 6'b000001, 1, 1);
    // sw, addi, j back to back
    add_fetch(OP_SW, 6'd0, 0);
    add_decode(OP_SW, 6'd0, 0, 0);
    add(OP_SW, 6'd0, 0, pack_exp(4'd2, 3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    add(OP_SW, 6'd0, 0, pack_exp(4'd5, 3'b010, 0, 2'b00, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0));
    add_fetch(OP_ADDI, 6'd0, 0);
    add_decode(OP_ADDI, 6'd0, 0, 0);
    add(OP_ADDI, 6'd0, 1, pack_exp(4'd9, 3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    add(OP_ADDI, 6'd0, 0, pack_exp(4'd10, 3'b010, 0, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0));
    add_fetch(OP_J, 6'd0, 0);
    add_decode(OP_J, 6'd0, 0, 0);
    add(OP_J, 6'd0, 0, pack_exp(4'd11, 3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b10, 1, 0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    build_table();

    // Reset state
    zero = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("reset_state", 32'(state), 32'd0);
    check("reset_ir_write", 32'(ir_write), 32'd0);
    check("reset_pc_en", 32'(pc_en), 32'd0);
    check("reset_src_b", 32'(alu_src_b), 32'(SRCB_FOUR));
    zero  = 1'b0;
    rst_n = 1'b1;

    // Table: apply inputs, settle, compare, advance one clock.
    for (int i = 0; i < vecs.size(); i++) begin
      opcode = vecs[i].op;
      funct  = vecs[i].fn;
      zero   = vecs[i].z;
      #1;
      n_tests++;
      if (dut_pack() !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL row%0d got=%h exp=%h", i, dut_pack(), vecs[i].exp);
      end
      @(posedge clk);
      #2;
    end
    check("after_table_state", 32'(state), 32'd0);

    // Reset in the middle of a store, held across 3 clocks.
    opcode = OP_SW;
    funct  = 6'd0;
    zero   = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (state == 4'd5) break;
      @(posedge clk);
      #2;
    end
    check("sw_reach_memwr", 32'(state), 32'd5);
    check("sw_mem_write", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_state", 32'(state), 32'd0);
    check("rst_async_mem_write", 32'(mem_write), 32'd0);
    check("rst_async_pc_en", 32'(pc_en), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #2;
      check("rst_hold_state", 32'(state), 32'd0);
      check("rst_hold_en", 32'({pc_en, ir_write, mem_write, reg_write}), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("rel_state", 32'(state), 32'd0);
    check("rel_ir_write", 32'(ir_write), 32'd1);
    check("rel_pc_en", 32'(pc_en), 32'd1);
    @(posedge clk);
    #2;
    check("rel_next_state", 32'(state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
